// File: rtl/vga_score_display_if.sv
// vga_score_display_if
//   Bundles the raster position, score controls and the render/score outputs
//   of vga_score_display. Clock and reset stay outside as plain ports.
//   slave  : the score renderer (consumes position/controls, drives outputs)
//   master : the game/top level side
//   Signals:
//     xpos, ypos         current pixel column/row from video_timer
//     originx, originy   top-left of the leftmost digit box
//     inc, clear, load   score controls (priority clear > load > inc)
//     load_value         nibble-packed value for load
//     blink_en           live blink enable
//     score, overflow    live BCD score and sticky wrap flag
//     pixel              registered segment-on flag
interface vga_score_display_if #(
  parameter int DIGITS = 4
);
  logic [9:0]          xpos;
  logic [9:0]          ypos;
  logic [9:0]          originx;
  logic [9:0]          originy;
  logic                inc;
  logic                clear;
  logic                load;
  logic [4*DIGITS-1:0] load_value;
  logic                blink_en;
  logic [4*DIGITS-1:0] score;
  logic                overflow;
  logic                pixel;

  modport master (
    output xpos, ypos, originx, originy, inc, clear, load, load_value, blink_en,
    input  score, overflow, pixel
  );

  modport slave (
    input  xpos, ypos, originx, originy, inc, clear, load, load_value, blink_en,
    output score, overflow, pixel
  );
endinterface

// File: rtl/vga_score_display.sv
// vga_score_display
//   Multi-digit seven-segment score renderer for the 640x480 VGA pipeline.
//   Holds a BCD score (clear/load/inc), snapshots score, origin and blink
//   phase at frame start (xpos==0 && ypos==0), and produces a registered
//   1-bit pixel flag one clk25 cycle after xpos/ypos.
//   Ports:
//     clk25  pixel clock
//     reset  asynchronous, active-high
//     bus    vga_score_display_if.slave (position, controls, score, pixel)
module vga_score_display #(
  parameter int DIGITS       = 4,
  parameter int SEG_W        = 4,
  parameter int SEG_L        = 16,
  parameter int DIGIT_GAP    = 8,
  parameter int LZB          = 1,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                 clk25,
  input  logic                 reset,
  vga_score_display_if.slave   bus
);

  localparam int unsigned SW      = 4 * DIGITS;
  localparam int unsigned BCNT_W  = $clog2(2 * BLINK_FRAMES);
  localparam int unsigned PITCH_I = 2 * SEG_W + SEG_L + DIGIT_GAP;

  // Geometry constants, all 11 bits so position arithmetic never wraps.
  localparam logic [10:0] TW    = 11'(SEG_W);
  localparam logic [10:0] BOX_W = 11'(2 * SEG_W + SEG_L);
  localparam logic [10:0] BOX_H = 11'(3 * SEG_W + 2 * SEG_L);
  localparam logic [10:0] X_R0  = 11'(SEG_W + SEG_L);
  localparam logic [10:0] Y_G0  = 11'(SEG_W + SEG_L);
  localparam logic [10:0] Y_L0  = 11'(2 * SEG_W + SEG_L);
  localparam logic [10:0] Y_D0  = 11'(2 * SEG_W + 2 * SEG_L);

  localparam logic [BCNT_W-1:0] BLINK_HALF = BCNT_W'(BLINK_FRAMES);
  localparam logic [BCNT_W-1:0] BLINK_LAST = BCNT_W'(2 * BLINK_FRAMES - 1);

  // Segment pattern {a,b,c,d,e,f,g} for the full hex set.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  // Live score state
  logic [SW-1:0]     score_q;
  logic [SW-1:0]     score_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              carry;

  // Per-frame display snapshot
  logic [SW-1:0]     disp_score;
  logic [9:0]        disp_ox;
  logic [9:0]        disp_oy;
  logic              disp_dark;
  logic [BCNT_W-1:0] blink_cnt;

  logic              frame_start;
  logic              pix_d;
  logic              pixel_q;

  assign frame_start  = (bus.xpos == '0) && (bus.ypos == '0);
  assign bus.score    = score_q;
  assign bus.overflow = ovf_q;
  assign bus.pixel    = pixel_q;

  // Score update: clear > load > inc. A full carry-out leaves every digit at 0.
  always_comb begin
    score_d = score_q;
    ovf_d   = ovf_q;
    carry   = 1'b0;
    if (bus.clear) begin
      score_d = '0;
      ovf_d   = 1'b0;
    end else if (bus.load) begin
      score_d = bus.load_value;
      ovf_d   = 1'b0;
    end else if (bus.inc) begin
      carry = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (score_q[4*i +: 4] >= 4'd9) begin
            score_d[4*i +: 4] = 4'd0;
          end else begin
            score_d[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
            carry             = 1'b0;
          end
        end
      end
      if (carry) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Rendering from the snapshot; on the frame-start cycle itself the old
  // snapshot is still in effect because the latch happens at that edge.
  logic [10:0]       px;
  logic [10:0]       py;
  logic [10:0]       oy;
  logic [10:0]       ry;
  logic [10:0]       box_x;
  logic [10:0]       rx;
  logic              in_row;
  logic              in_box;
  logic              row_a;
  logic              row_u;
  logic              row_g;
  logic              row_l;
  logic              row_d;
  logic              col_l;
  logic              col_m;
  logic              col_r;
  logic              seg_hit;
  logic              lead_zero;
  logic              hit;
  logic [6:0]        segs;
  logic [DIGITS-1:0] blank;

  always_comb begin
    px        = {1'b0, bus.xpos};
    py        = {1'b0, bus.ypos};
    oy        = {1'b0, disp_oy};
    ry        = py - oy;
    in_row    = (py >= oy) && (ry < BOX_H);
    row_a     = (ry < TW);
    row_u     = (ry >= TW)   && (ry < Y_G0);
    row_g     = (ry >= Y_G0) && (ry < Y_L0);
    row_l     = (ry >= Y_L0) && (ry < Y_D0);
    row_d     = (ry >= Y_D0);

    // Blanking walks down from the most significant digit; digit 0 never blanks.
    blank     = '0;
    lead_zero = (LZB != 0);
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      lead_zero = lead_zero && (disp_score[4*i +: 4] == 4'd0);
      blank[i]  = lead_zero;
    end

    hit     = 1'b0;
    box_x   = '0;
    rx      = '0;
    in_box  = 1'b0;
    col_l   = 1'b0;
    col_m   = 1'b0;
    col_r   = 1'b0;
    segs    = '0;
    seg_hit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      box_x   = {1'b0, disp_ox} + 11'((DIGITS - 1 - i) * PITCH_I);
      rx      = px - box_x;
      in_box  = in_row && (px >= box_x) && (rx < BOX_W);
      col_l   = (rx < TW);
      col_m   = (rx >= TW) && (rx < X_R0);
      col_r   = (rx >= X_R0);
      segs    = seg_decode(disp_score[4*i +: 4]);
      seg_hit = (segs[6] && col_m && row_a) ||
                (segs[5] && col_r && row_u) ||
                (segs[4] && col_r && row_l) ||
                (segs[3] && col_m && row_d) ||
                (segs[2] && col_l && row_l) ||
                (segs[1] && col_l && row_u) ||
                (segs[0] && col_m && row_g);
      if (in_box && seg_hit && !blank[i]) begin
        hit = 1'b1;
      end
    end

    pix_d = hit && !(disp_dark && bus.blink_en);
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      score_q    <= '0;
      ovf_q      <= 1'b0;
      disp_score <= '0;
      disp_ox    <= '0;
      disp_oy    <= '0;
      disp_dark  <= 1'b0;
      blink_cnt  <= '0;
      pixel_q    <= 1'b0;
    end else begin
      score_q <= score_d;
      ovf_q   <= ovf_d;
      pixel_q <= pix_d;
      if (frame_start) begin
        disp_score <= score_q;
        disp_ox    <= bus.originx;
        disp_oy    <= bus.originy;
        disp_dark  <= (blink_cnt >= BLINK_HALF);
        blink_cnt  <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/vga_score_display.md
# vga_score_display

Parametrised multi-digit seven-segment score renderer for the 640x480 VGA pipeline, clocked by the 25 MHz pixel clock. It holds a BCD score register with increment, clear and load controls, and renders it as bar-style segments at a movable origin. Its 1-bit pixel output is ORed into the game colour bus at top level. Score, origin and blink state are snapshotted once per frame so the image never tears.

## Interface
Parameters:
- DIGITS, 4, number of digits (1..8); digit 0 is least significant and drawn rightmost.
- SEG_W, 4, segment thickness in pixels.
- SEG_L, 16, segment length in pixels.
- DIGIT_GAP, 8, horizontal gap between digit boxes.
- LZB, 1, leading-zero blanking enable.
- BLINK_FRAMES, 32, half-period of blink, in frames.

Ports:
- clk25, in, 1, pixel clock.
- reset, in, 1, asynchronous, active-high.
- xpos, in, 10, current pixel column from video_timer.
- ypos, in, 10, current pixel row from video_timer.
- originx, in, 10, top-left X of the leftmost digit.
- originy, in, 10, top-left Y of the digit row.
- inc, in, 1, add 1 to the score (single-cycle pulse).
- clear, in, 1, set the score to 0.
- load, in, 1, load the score from load_value.
- load_value, in, 4*DIGITS, score value to load (nibbles).
- blink_en, in, 1, enable blinking.
- score, out, 4*DIGITS, live score register.
- overflow, out, 1, sticky wrap flag.
- pixel, out, 1, registered segment-on flag.

## Operation
- Score update priority: clear > load > inc, evaluated every cycle; the new value appears on score the next cycle.
  - clear: score <= 0, overflow <= 0.
  - load: score <= load_value, overflow <= 0.
  - inc: BCD ripple increment from digit 0. A digit with value >= 9 becomes 0 and carries; otherwise it adds 1.
  - If the carry propagates out of digit DIGITS-1, the score becomes 0 and overflow <= 1. overflow stays set until clear or load.
- Frame start is the cycle where xpos==0 and ypos==0. On that cycle the block latches score, originx, originy and the blink phase into display registers. Control changes during a frame take effect at the next frame start.
- Blink counter:
  - Counts frame starts modulo 2*BLINK_FRAMES.
  - Display is dark while counter >= BLINK_FRAMES and blink_en is high.
  - blink_en itself is sampled live, not latched.
- Geometry: W=SEG_W, L=SEG_L. Each digit box is (2W+L) wide and (3W+2L) high. Box k counted from the left (k=0 is digit DIGITS-1) starts at X = originx + k*(2W+L+DIGIT_GAP).
- All position arithmetic uses 11 bits, so no wrap occurs; a box extending past the screen edge is simply clipped.
- Segments, as half-open ranges relative to the box origin:
  - a: x[W,W+L), y[0,W)
  - b: x[W+L,2W+L), y[W,W+L)
  - c: x[W+L,2W+L), y[2W+L,2W+2L)
  - d: x[W,W+L), y[2W+2L,3W+2L)
  - e: x[0,W), y[2W+L,2W+2L)
  - f: x[0,W), y[W,W+L)
  - g: x[W,W+L), y[W+L,2W+L)
- Decode covers the full hex set 0-F (A, b, C, d, E, F), so out-of-range loaded values remain visible.
- Leading-zero blanking (LZB=1): a zero digit is blank if every more significant digit is also zero. Digit 0 is never blanked.
- pixel = in some digit box AND segment lit AND digit not blanked AND not blink-dark.

## Timing
- Reset values: score 0, overflow 0, pixel 0, latched score/origin 0, blink counter 0.
- pixel latency is exactly 1 clk25 cycle after xpos/ypos. The top level delays colour merges to match.
- Reset asserted mid-frame forces pixel to 0 on the next edge. Display registers stay 0 until the first frame start after reset release.
- Simultaneous inc and frame start: the frame latches the pre-increment score.
- Back-to-back inc pulses on consecutive cycles each count.

## Test plan
- Bench configuration for all cases: default parameters, origin (200,20), digit pitch 32.
- Reset, then 3 single-cycle inc pulses -> score=16'h0003, overflow=0.
- Score 16'h0001, run one frame:
  - Pixel (316,30) -> pixel=1 one cycle later (segment b of the rightmost digit).
  - Pixel (300,22) -> 0 (segment a, unlit for '1').
  - Any pixel in x 200..287 -> 0 (leading zeros blanked).
- load 16'h9999, then inc -> score=16'h0000, overflow=1. Assert clear and inc in the same cycle -> score=0, overflow=0.
- Change originx from 200 to 300 mid-frame -> current frame still draws at 200; drawing moves to 300 after the next (0,0).
- blink_en=1 with BLINK_FRAMES=2, score 8 -> segments visible for frames 0-1, dark for frames 2-3, visible again from frame 4.
- Assert reset at pixel (316,30) mid-frame -> pixel=0 from the next edge; score=0 immediately.
